weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// Weight loader: streams weight rows into a systolic PE array, one row per accepted beat.
// Optional stall timeout with ABORT state is enabled by defining WL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting weight beats, one row strobe per transfer
// FLUSH  | one-cycle gap after the final row strobe
// DONE   | completion pulse (clear_acc only when rows were loaded)
// ABORT  | stall timeout pulse, err set (WL_TIMEOUT_EN only)
module weight_loader #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(ROWS+1)-1:0]  num_rows,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [COLS*DATA_W-1:0]     w_data,
   output logic [ROWS-1:0]            load_weight,
   output logic [COLS*DATA_W-1:0]     weight_out,
   output logic                       clear_acc,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int CNT_W = $clog2(ROWS+1);
   localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("weight_loader: TIMEOUT_CYC must be at least 1");
   end

`ifdef WL_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ABORT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rows_q;
   logic [CNT_W-1:0]  row_cnt_q;
   logic [CNT_W-1:0]  rows_clamped;
   logic              flushed_q;
   logic              accept;
   logic              last_beat;
   logic              stall_hit;

   assign rows_clamped = (num_rows > ROWS_C) ? ROWS_C : num_rows;
   assign w_ready      = (state_q == S_LOAD);
   assign accept       = (state_q == S_LOAD) && w_valid;
   assign last_beat    = accept && (row_cnt_q == rows_q - CNT_W'(1));

`ifdef WL_TIMEOUT_EN
   localparam int ST_W = $clog2(TIMEOUT_CYC+1);
   logic [ST_W-1:0] stall_cnt_q;
   logic            err_q;

   assign stall_hit = (state_q == S_LOAD) && !accept &&
                      (stall_cnt_q == ST_W'(TIMEOUT_CYC-1));
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if ((state_q == S_LOAD) && !accept) stall_cnt_q <= stall_cnt_q + ST_W'(1);
         else                                stall_cnt_q <= '0;
         // err stays up through IDLE until the next accepted start
         if ((state_q == S_IDLE) && start) err_q <= 1'b0;
         else if (stall_hit)               err_q <= 1'b1;
      end
   end
`else
   assign stall_hit = 1'b0;
   assign err       = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      busy      = 1'b1;
      done      = 1'b0;
      clear_acc = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = (rows_clamped == '0) ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            if (last_beat)      state_d = S_FLUSH;
            else if (stall_hit) state_d = state_t'(S_DONE + 1);
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            clear_acc = flushed_q;
            state_d   = S_IDLE;
         end
`ifdef WL_TIMEOUT_EN
         S_ABORT: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rows_q      <= '0;
         row_cnt_q   <= '0;
         flushed_q   <= 1'b0;
         load_weight <= '0;
         weight_out  <= '0;
      end else begin
         state_q     <= state_d;
         // marks a DONE entered from FLUSH, as opposed to a zero-row start
         flushed_q   <= (state_q == S_FLUSH);
         load_weight <= '0;
         if ((state_q == S_IDLE) && start) begin
            rows_q    <= rows_clamped;
            row_cnt_q <= '0;
         end
         if (accept) begin
            load_weight <= ROWS'(1) << row_cnt_q;
            weight_out  <= w_data;
            row_cnt_q   <= row_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule
